// File: rtl/snake_pkg.sv
// Shared types for the snake head mover: direction encoding and mover FSM states.
package snake_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    UP    = 2'b10,
    DOWN  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DEAD = 2'b10
  } mover_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running game-tick divider: tick is high on the enabled cycle where the count reaches DIV-1.
module tick_divider #(
  parameter int DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = en && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/snake_head_mover.sv
// Moves the snake head one cell per game tick, stops on a wall hit and supports restart.
module snake_head_mover
  import snake_pkg::*;
#(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 16,
  parameter int TICK_DIV = 12500000,
  parameter int START_X  = 2,
  parameter int START_Y  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      pause,
  input  logic [3:0]                dir_in,
  output logic [$clog2(GRID_W)-1:0] head_x,
  output logic [$clog2(GRID_H)-1:0] head_y,
  output logic                      move_pulse,
  output logic                      running,
  output logic                      game_over
);

  localparam int XW = $clog2(GRID_W);
  localparam int YW = $clog2(GRID_H);
  localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
  localparam logic [XW-1:0] X_START = XW'(START_X);
  localparam logic [YW-1:0] Y_START = YW'(START_Y);

  mover_state_t  state;
  dir_t          dir;
  logic          tick;
  logic          div_en;
  logic          div_clr;
  logic          hit;
  logic [XW-1:0] next_x;
  logic [YW-1:0] next_y;
  logic          unused_dir_bits;

  assign unused_dir_bits = ^dir_in[3:2];
  assign dir     = dir_t'(dir_in[1:0]);
  assign div_en  = (state == RUN) && !pause;
  assign div_clr = (state != RUN);

  tick_divider #(.DIV(TICK_DIV)) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .clr   (div_clr),
    .tick  (tick)
  );

  // Wall check comes first so an out-of-grid coordinate is never computed into the head.
  always_comb begin
    next_x = head_x;
    next_y = head_y;
    hit    = 1'b0;
    case (dir)
      LEFT:  if (head_x == '0)  hit = 1'b1; else next_x = head_x - XW'(1);
      RIGHT: if (head_x == X_MAX) hit = 1'b1; else next_x = head_x + XW'(1);
      UP:    if (head_y == '0)  hit = 1'b1; else next_y = head_y - YW'(1);
      DOWN:  if (head_y == Y_MAX) hit = 1'b1; else next_y = head_y + YW'(1);
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      head_x     <= X_START;
      head_y     <= Y_START;
      move_pulse <= 1'b0;
      running    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      move_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (tick) begin
            if (hit) begin
              state     <= DEAD;
              running   <= 1'b0;
              game_over <= 1'b1;
            end else begin
              head_x     <= next_x;
              head_y     <= next_y;
              move_pulse <= 1'b1;
            end
          end
        end
        DEAD: begin
          if (start) begin
            state     <= RUN;
            head_x    <= X_START;
            head_y    <= Y_START;
            running   <= 1'b1;
            game_over <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          running   <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
  end

endmodule
